// File: rtl/heart_sprite.sv
// Player heart for the battle screen: per-frame button movement clamped to the
// border's inner area, hit/invulnerability timer with blinking, registered sprite pixel.
module heart_sprite #(
  parameter int unsigned SIZE       = 16,
  parameter int unsigned STEP       = 2,
  parameter int unsigned INV_FRAMES = 60,
  parameter int unsigned FRAME_Y    = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] state,
  input  logic [9:0] leftBorder,
  input  logic [9:0] rightBorder,
  input  logic [9:0] topBorder,
  input  logic [9:0] bottomBorder,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  output logic       heartSpriteOn,
  output logic [9:0] heart_x,
  output logic [9:0] heart_y,
  output logic       invulnerable
);

  localparam int unsigned INV_W = (INV_FRAMES > 1) ? $clog2(INV_FRAMES) : 1;
  localparam logic [9:0]  RST_X = 10'(((120 + 520) >> 1) - (SIZE / 2));
  localparam logic [9:0]  RST_Y = 10'(((100 + 380) >> 1) - (SIZE / 2));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HIT    = 2'd2
  } fsm_e;

  fsm_e             fsm_q;
  logic [9:0]       heart_x_q, heart_y_q;
  logic [9:0]       heart_x_d, heart_y_d;
  logic [INV_W-1:0] inv_cnt_q;
  logic [2:0]       blink_q;
  logic             tick_q;
  logic             inv_q;
  logic             sprite_q;

  logic             battle_c;
  logic [9:0]       cx_c, cy_c;
  logic [10:0]      hx_c, hy_c, px_c, py_c;
  logic [10:0]      lo_x_c, hi_x_c, lo_y_c, hi_y_c;
  logic             raw_c, visible_c;

  // Centre, legal range, clamped one-tick move and hit-box, all in 11 bits so nothing wraps.
  always_comb begin
    battle_c  = (state == 2'd1) || (state == 2'd2);
    cx_c      = 10'(((11'(leftBorder) + 11'(rightBorder)) >> 1) - 11'(SIZE / 2));
    cy_c      = 10'(((11'(topBorder) + 11'(bottomBorder)) >> 1) - 11'(SIZE / 2));
    hx_c      = 11'(heart_x_q);
    hy_c      = 11'(heart_y_q);
    px_c      = 11'(x);
    py_c      = 11'(y);
    lo_x_c    = 11'(leftBorder) + 11'd1;
    hi_x_c    = 11'(rightBorder) - 11'(SIZE);
    lo_y_c    = 11'(topBorder) + 11'd1;
    hi_y_c    = 11'(bottomBorder) - 11'(SIZE);
    heart_x_d = heart_x_q;
    heart_y_d = heart_y_q;

    if (btn_left && !btn_right) begin
      heart_x_d = (hx_c < lo_x_c + 11'(STEP)) ? 10'(lo_x_c) : 10'(hx_c - 11'(STEP));
    end else if (btn_right && !btn_left) begin
      heart_x_d = (hx_c + 11'(STEP) > hi_x_c) ? 10'(hi_x_c) : 10'(hx_c + 11'(STEP));
    end

    if (btn_up && !btn_down) begin
      heart_y_d = (hy_c < lo_y_c + 11'(STEP)) ? 10'(lo_y_c) : 10'(hy_c - 11'(STEP));
    end else if (btn_down && !btn_up) begin
      heart_y_d = (hy_c + 11'(STEP) > hi_y_c) ? 10'(hi_y_c) : 10'(hy_c + 11'(STEP));
    end

    raw_c     = (px_c >= hx_c) && (px_c < hx_c + 11'(SIZE)) &&
                (py_c >= hy_c) && (py_c < hy_c + 11'(SIZE));
    visible_c = (fsm_q == S_ACTIVE) || ((fsm_q == S_HIT) && !blink_q[2]);
  end

  // Frame tick, sprite pixel and the IDLE/ACTIVE/HIT controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q     <= S_IDLE;
      heart_x_q <= RST_X;
      heart_y_q <= RST_Y;
      inv_cnt_q <= '0;
      blink_q   <= '0;
      tick_q    <= 1'b0;
      inv_q     <= 1'b0;
      sprite_q  <= 1'b0;
    end else begin
      tick_q   <= (x == 10'd0) && (y == 10'(FRAME_Y));
      sprite_q <= raw_c && visible_c;

      case (fsm_q)
        S_IDLE: begin
          heart_x_q <= cx_c;
          heart_y_q <= cy_c;
          if (battle_c) fsm_q <= S_ACTIVE;
        end

        S_ACTIVE: begin
          if (!battle_c) begin
            fsm_q <= S_IDLE;
          end else begin
            if (tick_q) begin
              heart_x_q <= heart_x_d;
              heart_y_q <= heart_y_d;
            end
            if (hit) begin
              fsm_q     <= S_HIT;
              inv_q     <= 1'b1;
              inv_cnt_q <= INV_W'(INV_FRAMES - 1);
              blink_q   <= '0;
            end
          end
        end

        S_HIT: begin
          if (!battle_c) begin
            fsm_q     <= S_IDLE;
            inv_q     <= 1'b0;
            inv_cnt_q <= '0;
            blink_q   <= '0;
          end else if (tick_q) begin
            heart_x_q <= heart_x_d;
            heart_y_q <= heart_y_d;
            blink_q   <= blink_q + 3'd1;
            if (inv_cnt_q == '0) begin
              fsm_q <= S_ACTIVE;
              inv_q <= 1'b0;
            end else begin
              inv_cnt_q <= inv_cnt_q - INV_W'(1);
            end
          end
        end

        default: begin
          fsm_q <= S_IDLE;
          inv_q <= 1'b0;
        end
      endcase
    end
  end

  assign heartSpriteOn = sprite_q;
  assign heart_x       = heart_x_q;
  assign heart_y       = heart_y_q;
  assign invulnerable  = inv_q;

endmodule
